// File: rtl/serial_parity_ctrl.sv
// Bit-serial XOR/XNOR reduction of a WIDTH-bit word through one shared XOR and an accumulator.
// Optional abort input is compiled in when SERIAL_PARITY_ABORT_EN is defined.
module serial_parity_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
`ifdef SERIAL_PARITY_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             result
);

  // Handshake: start is sampled only while idle (busy=0, done=0); busy is high for
  // exactly WIDTH cycles, then done pulses for one cycle with result already valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      shreg  <= '0;
      acc    <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            shreg  <= din;
            mode_q <= mode;
            acc    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef SERIAL_PARITY_ABORT_EN
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else
`endif
          begin
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            if (cnt == LAST) begin
              // Fold in the last bit here so result is valid alongside done.
              result <= acc ^ shreg[0] ^ mode_q;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_ctrl.sv
// Directed bench for serial_parity_ctrl: a schedule-based parity model checked every cycle,
// plus literal expectations on result, busy length and done timing.
module tb_serial_parity_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             result;

  int tests = 0;
  int fails = 0;

  serial_parity_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (rst),
    .start  (start),
    .mode   (mode),
    .din    (din),
`ifdef SERIAL_PARITY_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted word at edge s gives busy after edges s..s+WIDTH-1,
  // done after edge s+WIDTH with result = parity(din) ^ mode.
  int   cyc = 0;
  int   s_edge = 0;
  int   next_free = 0;
  bit   active = 0;
  logic pend = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic exp_result = 1'b0;
  logic abort_eff;

`ifdef SERIAL_PARITY_ABORT_EN
  assign abort_eff = abort;
`else
  assign abort_eff = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active     = 0;
      next_free  = 0;
      cyc        = 0;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_result = 1'b0;
    end else begin
      cyc++;
      if (active && abort_eff && cyc > s_edge && cyc <= s_edge + WIDTH) begin
        active    = 0;
        next_free = cyc + 1;
      end else if (!active && start && cyc >= next_free) begin
        active    = 1;
        s_edge    = cyc;
        pend      = (^din) ^ mode;
        next_free = cyc + WIDTH + 2;
      end
      exp_busy = active && cyc >= s_edge && cyc < s_edge + WIDTH;
      exp_done = active && cyc == s_edge + WIDTH;
      if (exp_done) begin
        exp_result = pend;
        active     = 0;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("result", 32'(result), 32'(exp_result));
  end

  // driver tasks
  int busy_cnt;
  int done_cnt;
  int done_pos;

  // Launch one word and watch up to 20 cycles; returns busy length and done position.
  task automatic run_word(input logic [WIDTH-1:0] d, input logic m);
    @(negedge clk);
    din   = d;
    mode  = m;
    start = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    done_pos = -1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_pos < 0) done_pos = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_word(input string name, input logic [WIDTH-1:0] d, input logic m,
                             input logic exp_r);
    run_word(d, m);
    check({name, "_busy_len"}, 32'(busy_cnt), 32'(WIDTH));
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_done_pos"}, 32'(done_pos), 32'(WIDTH + 1));
    check({name, "_result"}, 32'(result), 32'(exp_r));
  endtask

`ifdef SERIAL_PARITY_ABORT_EN
  task automatic run_abort(input logic [WIDTH-1:0] d, input int at_edge);
    @(negedge clk);
    din   = d;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (at_edge - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask
`endif

  int seen;
  int last_done;
  int gap_ok;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;

    expect_word("a5_xor", 8'hA5, 1'b0, 1'b0);
    expect_word("a5_xnor", 8'hA5, 1'b1, 1'b1);
    expect_word("07_xor", 8'h07, 1'b0, 1'b1);
    expect_word("00_xnor", 8'h00, 1'b1, 1'b1);
    expect_word("ff_xor", 8'hFF, 1'b0, 1'b0);

    // start held high: one word per WIDTH+2 cycles; din disturbed while busy
    @(negedge clk);
    din   = 8'h01;
    mode  = 1'b0;
    start = 1'b1;
    seen = 0;
    last_done = -1;
    gap_ok = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      din = busy ? 8'h03 : 8'h01;
      if (done) begin
        seen++;
        if (last_done >= 0 && i - last_done != WIDTH + 2) gap_ok = 0;
        last_done = i;
        check("hold_result", 32'(result), 32'd1);
      end
    end
    start = 1'b0;
    din   = 8'h00;
    check("hold_done_cnt", 32'(seen), 32'd3);
    check("hold_spacing", 32'(gap_ok), 32'd1);
    repeat (12) @(negedge clk);

    // async reset in the middle of a run
    din   = 8'hFF;
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_word("80_after_rst", 8'h80, 1'b0, 1'b1);

`ifdef SERIAL_PARITY_ABORT_EN
    check("pre_abort_result", 32'(result), 32'd1);
    run_abort(8'h00, 3);
    check("abort3_done_cnt", 32'(done_cnt), 32'd0);
    check("abort3_result", 32'(result), 32'd1);
    run_abort(8'h00, WIDTH);
    check("abort_last_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_last_result", 32'(result), 32'd1);
    expect_word("after_abort", 8'h03, 1'b1, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_parity_ctrl.md
Name: serial_parity_ctrl

Overview:
Sequencing controller that computes XOR (odd-parity) or XNOR (even-parity) reduction of a WIDTH-bit word by streaming one bit per clock through a single shared 2-input XOR cell with an accumulator. It replaces a wide combinational XOR/XNOR tree where area matters more than latency. A start/busy/done handshake lets a host FSM launch a reduction and collect the result.

Parameters:
WIDTH, 8, bits per operand word (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = XOR reduction, 1 = XNOR reduction; latched with start
din  input  WIDTH  operand word; latched with start
busy  output  1  high while a reduction is in progress (RUN state)
done  output  1  one-cycle pulse when result is updated
result  output  1  reduction result; holds until next done
abort  input  1  present only when SERIAL_PARITY_ABORT_EN defined

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-high.
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, shift register=0, accumulator=0, counter=0, latched mode=0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: busy=0, done=0. On start=1: shreg<=din, mode_q<=mode, acc<=0, cnt<=0, go RUN.
- RUN: busy=1. Each cycle: acc<=acc^shreg[0]; shreg<=shreg>>1 (zero fill); cnt<=cnt+1. When cnt==WIDTH-1 (last bit consumed this cycle): go DONE.
- DONE: busy=0; done=1 for exactly this cycle; result<=acc^mode_q registered on entry so it is valid in the same cycle done is high; next state IDLE unconditionally.
- Latency: start sampled at edge 0 -> busy high for cycles 1..WIDTH -> done high in cycle WIDTH+1 -> IDLE in cycle WIDTH+2. Back-to-back throughput: one word per WIDTH+2 cycles.
- start in RUN or DONE: ignored, not queued; din/mode changes outside IDLE have no effect.
- result stable between done pulses; not cleared by a new start.
- XNOR semantics: result = ~(^din) for any WIDTH (true even-parity flag), not a chained pairwise xnor2 value.
- Counter never exceeds WIDTH-1; no wrap-around possible.
- Reset asserted mid-RUN: immediate return to IDLE, no done pulse, result forced to 0.

Optional Feature:
SERIAL_PARITY_ABORT_EN
- Defined: abort input exists. abort=1 in RUN -> next state IDLE, busy drops next cycle, no done pulse, result unchanged. abort in IDLE/DONE ignored; abort has priority over completion on the last RUN cycle.
- Undefined: no abort port; RUN always runs WIDTH cycles to DONE.

Test Plan:
- WIDTH=8, din=8'hA5, mode=0, start 1 cycle -> busy high 8 cycles, done pulse in cycle 9, result=0; mode=1 same word -> result=1.
- din=8'h07, mode=0 -> result=1; then din=8'h00, mode=1 -> result=1; din=8'hFF, mode=0 -> result=0.
- Hold start high continuously with din=8'h01 -> reductions every 10 cycles, each result=1; toggling din to 8'h03 during RUN does not affect the in-flight result.
- Assert reset at cycle 4 of RUN -> busy=0, result=0 asynchronously, no done; next start with 8'h80, mode=0 -> result=1.
- With SERIAL_PARITY_ABORT_EN: prior result=1, start din=8'h00 mode=0, abort at RUN cycle 3 -> IDLE, no done, result stays 1; abort on 8th RUN cycle also suppresses done.
